// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin-type encoding, coin unit values and the credit width.
package vend_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COLLECT  = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_CHANGE   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  localparam logic [CREDIT_W-1:0] NICKEL_UNITS  = 4'd1;
  localparam logic [CREDIT_W-1:0] DIME_UNITS    = 4'd2;
  localparam logic [CREDIT_W-1:0] QUARTER_UNITS = 4'd5;

  // Value of a coin in 5-cent units; "none" is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] coin_type);
    logic [CREDIT_W-1:0] units;
    units = '0;
    case (coin_type)
      COIN_NICKEL:  units = NICKEL_UNITS;
      COIN_DIME:    units = DIME_UNITS;
      COIN_QUARTER: units = QUARTER_UNITS;
      default:      units = '0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/adder_4bit.sv
// Plain 4-bit ripple adder with carry in/out, used for credit accumulation.
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = 5'(a_i) + 5'(b_i) + 5'(cin_i);

endmodule

// File: rtl/vend_ctrl.sv
// Coin-operated vending controller: accumulates credit, dispenses one item
// at PRICE, returns change with a handshake and rejects coins that would
// overflow the 4-bit credit or arrive while busy.
// Optional refund-on-cancel in COLLECT is enabled by defining VEND_CANCEL_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_type,
  input  logic       i_cancel,
  input  logic       i_change_ack,
  output logic [3:0] o_credit,
  output logic       o_dispense,
  output logic [3:0] o_change,
  output logic       o_change_valid,
  output logic       o_coin_reject,
  output logic       o_busy
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                reject_q, reject_d;

  logic                coin_real;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                carry;
  logic [CREDIT_W-1:0] credit_eff;

`ifndef VEND_CANCEL_EN
  // Cancel has no function in this build; the input is deliberately left dangling.
  logic unused_cancel;
  assign unused_cancel = i_cancel;
`endif

  // A strobe with type "none" is not a coin at all: no credit, no reject.
  assign coin_real = i_coin_valid && (i_coin_type != COIN_NONE);
  assign coin_val  = coin_units(i_coin_type);

  adder_4bit u_adder (
    .a_i    (credit_q),
    .b_i    (coin_val),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // State, credit, pending change and reject pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      change_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      reject_q <= reject_d;
    end
  end

  // Next-state, credit update and coin accept/reject decisions.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    reject_d   = 1'b0;
    credit_eff = credit_q;
    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        change_d = '0;
        if (coin_real) begin
          if (carry) begin
            reject_d = 1'b1;
          end else begin
            credit_d = sum;
            state_d  = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
`ifdef VEND_CANCEL_EN
        // Cancel wins over a coin in the same cycle: refund everything held.
        if (i_cancel) begin
          state_d  = ST_CHANGE;
          change_d = credit_q;
          reject_d = coin_real;
        end else begin
`else
        begin
`endif
          if (coin_real) begin
            if (carry) begin
              reject_d = 1'b1;
            end else begin
              credit_eff = sum;
            end
          end
          credit_d = credit_eff;
          // Checked on held credit too, so a large first coin still vends.
          if (credit_eff >= PRICE_C) begin
            state_d = ST_DISPENSE;
          end
        end
      end
      ST_DISPENSE: begin
        reject_d = coin_real;
        if (credit_q > PRICE_C) begin
          state_d  = ST_CHANGE;
          change_d = credit_q - PRICE_C;
        end else begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end
      ST_CHANGE: begin
        reject_d = coin_real;
        if (i_change_ack) begin
          state_d  = ST_IDLE;
          credit_d = '0;
          change_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        change_d = '0;
      end
    endcase
  end

  assign o_credit       = credit_q;
  assign o_dispense     = (state_q == ST_DISPENSE);
  assign o_change_valid = (state_q == ST_CHANGE);
  assign o_change       = (state_q == ST_CHANGE) ? change_q : '0;
  assign o_coin_reject  = reject_q;
  assign o_busy         = (state_q == ST_DISPENSE) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: a PRICE=4 instance driven through vend/change/cancel/
// reset sequences with a scoreboard on its output events, and a PRICE=15
// instance for overflow and exact-price boundaries.
module tb_vend_ctrl;

  localparam int EV_DISP = 0;
  localparam int EV_CHG  = 1;
  localparam int EV_REJ  = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk;
  logic       rst_n;

  logic       a_cv_in, a_cancel, a_ack;
  logic [1:0] a_type;
  logic [3:0] a_credit, a_change;
  logic       a_disp, a_cv, a_rej, a_busy;

  logic       b_cv_in, b_cancel, b_ack;
  logic [1:0] b_type;
  logic [3:0] b_credit, b_change;
  logic       b_disp, b_cv, b_rej, b_busy;

  int  total;
  int  bad;
  ev_t exp_q[$];
  logic cv_prev;

  vend_ctrl #(.PRICE(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_coin_valid(a_cv_in), .i_coin_type(a_type),
    .i_cancel(a_cancel), .i_change_ack(a_ack),
    .o_credit(a_credit), .o_dispense(a_disp),
    .o_change(a_change), .o_change_valid(a_cv),
    .o_coin_reject(a_rej), .o_busy(a_busy)
  );

  vend_ctrl #(.PRICE(15)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_coin_valid(b_cv_in), .i_coin_type(b_type),
    .i_cancel(b_cancel), .i_change_ack(b_ack),
    .o_credit(b_credit), .o_dispense(b_disp),
    .o_change(b_change), .o_change_valid(b_cv),
    .o_coin_reject(b_rej), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic mon_event(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event actual=%0d required=none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == EV_CHG) chk("event_change", val, e.val);
    end
  endtask

  // Monitor: pops one expectation per output event of the PRICE=4 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_disp) mon_event(EV_DISP, 0);
      if (a_cv && !cv_prev) mon_event(EV_CHG, int'(a_change));
      if (a_rej) mon_event(EV_REJ, 0);
    end
    cv_prev <= a_cv;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic coin_a(input logic [1:0] t);
    a_cv_in = 1'b1;
    a_type  = t;
    step();
    a_cv_in = 1'b0;
    a_type  = 2'b00;
  endtask

  task automatic coin_b(input logic [1:0] t);
    b_cv_in = 1'b1;
    b_type  = t;
    step();
    b_cv_in = 1'b0;
    b_type  = 2'b00;
  endtask

  task automatic wait_cv_a();
    for (int i = 0; i < 20 && !a_cv; i++) step();
    chk("change_valid_reached", int'(a_cv), 1);
  endtask

  task automatic ack_a();
    a_ack = 1'b1;
    step();
    a_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cv_prev = 1'b0;
    rst_n = 1'b0;
    a_cv_in = 0; a_type = 0; a_cancel = 0; a_ack = 0;
    b_cv_in = 0; b_type = 0; b_cancel = 0; b_ack = 0;
    #2;
    chk("rst_credit", int'(a_credit), 0);
    chk("rst_outputs", int'({a_disp, a_cv, a_rej, a_busy}), 0);
    chk("rst_change", int'(a_change), 0);
    #10;
    rst_n = 1'b1;
    step();

    // PRICE=15: "none" coin ignored, overflow reject, exact price vend.
    coin_b(2'b00);
    chk("none_credit", int'(b_credit), 0);
    chk("none_reject", int'(b_rej), 0);
    chk("none_busy", int'(b_busy), 0);
    coin_b(2'b11);
    chk("b_credit_5", int'(b_credit), 5);
    coin_b(2'b11);
    chk("b_credit_10", int'(b_credit), 10);
    coin_b(2'b10);
    chk("b_credit_12", int'(b_credit), 12);
    coin_b(2'b11);
    chk("ovf_reject", int'(b_rej), 1);
    chk("ovf_credit_kept", int'(b_credit), 12);
    step();
    chk("ovf_reject_pulse_end", int'(b_rej), 0);
    coin_b(2'b10);
    chk("b_credit_14", int'(b_credit), 14);
    coin_b(2'b01);
    chk("b_credit_15", int'(b_credit), 15);
    chk("b_dispense", int'(b_disp), 1);
    step();
    chk("b_idle_credit", int'(b_credit), 0);
    chk("b_no_change", int'(b_cv), 0);

    // PRICE=4: dime, dime -> vend with no change.
    coin_a(2'b10);
    chk("dd_credit_2", int'(a_credit), 2);
    push(EV_DISP, 0);
    coin_a(2'b10);
    chk("dd_credit_4", int'(a_credit), 4);
    step();
    chk("dd_idle_credit", int'(a_credit), 0);
    chk("dd_idle_busy", int'(a_busy), 0);

    // PRICE=4: quarter -> vend, change 1 held; coin while busy rejected.
    push(EV_DISP, 0);
    push(EV_CHG, 1);
    coin_a(2'b11);
    chk("q_credit_5", int'(a_credit), 5);
    wait_cv_a();
    step();
    step();
    chk("q_change_held", int'(a_change), 1);
    push(EV_REJ, 0);
    coin_a(2'b10);
    chk("busy_reject", int'(a_rej), 1);
    chk("busy_change_kept", int'(a_change), 1);
    chk("busy_credit_kept", int'(a_credit), 5);
    ack_a();
    chk("ack_credit", int'(a_credit), 0);
    chk("ack_cv", int'(a_cv), 0);
    chk("ack_change_zero", int'(a_change), 0);

    // Ack outside CHANGE is ignored.
    a_ack = 1'b1;
    coin_a(2'b01);
    step();
    a_ack = 1'b0;
    chk("stray_ack_credit", int'(a_credit), 1);
    chk("stray_ack_busy", int'(a_busy), 0);
    coin_a(2'b10);
    chk("nd_credit_3", int'(a_credit), 3);

`ifdef VEND_CANCEL_EN
    // Cancel with a coin in the same cycle: coin rejected, full refund.
    push(EV_CHG, 3);
    push(EV_REJ, 0);
    a_cancel = 1'b1;
    coin_a(2'b11);
    a_cancel = 1'b0;
    chk("cancel_change", int'(a_change), 3);
    chk("cancel_credit", int'(a_credit), 3);
    chk("cancel_reject", int'(a_rej), 1);
`else
    // Cancel ignored: the coin is accepted and the sale proceeds.
    push(EV_DISP, 0);
    push(EV_CHG, 1);
    a_cancel = 1'b1;
    coin_a(2'b10);
    a_cancel = 1'b0;
    chk("nocancel_credit", int'(a_credit), 5);
    wait_cv_a();
    ack_a();
    chk("nocancel_ack_credit", int'(a_credit), 0);
    coin_a(2'b10);
    push(EV_DISP, 0);
    push(EV_CHG, 3);
    coin_a(2'b11);
    chk("dq_credit_7", int'(a_credit), 7);
    wait_cv_a();
    chk("dq_change", int'(a_change), 3);
`endif

    // Asynchronous reset in the middle of CHANGE discards pending change.
    step();
    chk("pre_rst_cv", int'(a_cv), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_change", int'(a_change), 0);
    chk("arst_credit", int'(a_credit), 0);
    chk("arst_outputs", int'({a_disp, a_cv, a_rej, a_busy}), 0);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_credit", int'(a_credit), 0);
    chk("post_rst_busy", int'(a_busy), 0);
    chk("post_rst_cv", int'(a_cv), 0);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL global_timeout actual=stalled required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 PRICE, 4, item price in 5-cent units, legal range 1..15.
REQ-002 i_clk  input  1  system clock, rising-edge active.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_coin_valid  input  1  one-cycle coin strobe.
REQ-005 i_coin_type  input  2  00 none, 01 nickel (1 unit), 10 dime (2), 11 quarter (5).
REQ-006 i_cancel  input  1  refund request, level-sampled.
REQ-007 i_change_ack  input  1  change-return mechanism has taken o_change.
REQ-008 o_credit  output  4  registered accumulated credit, 5-cent units.
REQ-009 o_dispense  output  1  one-cycle item-release pulse.
REQ-010 o_change  output  4  change amount, valid only with o_change_valid.
REQ-011 o_change_valid  output  1  change pending, held until acknowledged.
REQ-012 o_coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-013 o_busy  output  1  high in DISPENSE and CHANGE.

Function
REQ-014 States: IDLE, COLLECT, DISPENSE, CHANGE, encoded as a 2-bit enum.
REQ-015 Coin value decode per REQ-005; i_coin_type 00 with i_coin_valid high SHALL be ignored with no reject.
REQ-016 Accepted coin sampled in cycle N SHALL appear on o_credit in cycle N+1.
REQ-017 Credit sum SHALL be 4-bit unsigned; a coin whose addition produces a carry-out SHALL be rejected, credit unchanged, o_coin_reject high in N+1.
REQ-018 IDLE: credit 0; valid coin -> add, go COLLECT.
REQ-019 COLLECT: valid coin -> add; when the updated credit >= PRICE, next state DISPENSE, otherwise remain.
REQ-020 DISPENSE: lasts exactly one cycle with o_dispense=1; next state CHANGE if credit > PRICE, otherwise IDLE with credit cleared.
REQ-021 CHANGE: o_change = credit - PRICE (or full credit after cancel), o_change_valid=1; stay until i_change_ack=1, then IDLE with credit cleared on the same edge.
REQ-022 i_change_ack outside CHANGE SHALL be ignored.
REQ-023 Any valid coin in DISPENSE or CHANGE SHALL be rejected (o_coin_reject pulse in the next cycle).
REQ-024 o_change SHALL read 0 whenever o_change_valid=0.

Reset
REQ-025 Asynchronous assertion of i_rst_n=0 SHALL force IDLE, credit 0, and all outputs 0 immediately, including mid-CHANGE (pending change discarded).
REQ-026 The first state update SHALL occur on the first rising i_clk after i_rst_n deasserts.

Configuration
REQ-027 Macro VEND_CANCEL_EN defined: in COLLECT, i_cancel=1 -> CHANGE with o_change = full credit and no o_dispense; a coin in the same cycle is rejected (cancel wins); cancel in IDLE, DISPENSE, or CHANGE is ignored.
REQ-028 Macro VEND_CANCEL_EN undefined: i_cancel SHALL be ignored in all states, with no logic generated for it.

Structure
REQ-029 Package vend_pkg SHALL hold the state enum, the coin-type encoding, the coin unit values (1/2/5), and the credit width (4).
REQ-030 Credit accumulation SHALL instantiate the existing adder_4bit (cin=0); its carry-out drives the overflow reject; all other logic stays inline.

Verification
REQ-031 PRICE=4: dime, dime -> o_credit 2 then 4, o_dispense pulse in the next cycle, no change, return to IDLE.
REQ-032 PRICE=4: quarter -> o_dispense, then o_change_valid=1, o_change=1 held until i_change_ack, then credit 0.
REQ-033 PRICE=15: credit 12 plus quarter -> o_coin_reject pulse, credit stays 12.
REQ-034 VEND_CANCEL_EN defined: nickel, dime, then i_cancel with a coin in the same cycle -> coin rejected, o_change=3, no o_dispense.
REQ-035 i_rst_n asserted during CHANGE with o_change=3 -> all outputs 0 asynchronously; after release, IDLE with credit 0.
REQ-036 Coin inserted while o_busy=1 -> o_coin_reject pulse, o_change unchanged.
